// File: rtl/dbg_uart_dump.sv
// -----------------------------------------------------------------------------
// dbg_uart_dump
//
// Debug-bus consumer for post-mortem CPU inspection. A 0->1 edge on trigger
// snapshots the program counter. The block then walks dbg_reg_sel through
// x0..x31 and sends 33 records over an 8N1 UART TX line. Each record is
// 8 uppercase hex digits (MS nibble first) followed by CR LF.
// Record 0 is the PC snapshot; record r (1..32) is register r-1.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   trigger       dump request, acted on at its rising edge while idle
//   dbg_pc        program counter from the core
//   dbg_reg_data  register-file read data for dbg_reg_sel
//   dbg_reg_sel   register index presented to the core
//   tx            UART serial output, idle high
//   busy          high while a dump is in progress
// -----------------------------------------------------------------------------
module dbg_uart_dump #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [31:0] dbg_pc,
  input  logic [31:0] dbg_reg_data,
  output logic [4:0]  dbg_reg_sel,
  output logic        tx,
  output logic        busy
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0]        LAST_REC  = 6'd32;
  localparam logic [3:0]        LAST_BYTE = 4'd9;
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t            state_reg;
  logic              trig_prev_reg;
  logic [31:0]       pc_snap_reg;
  logic [31:0]       word_reg;
  logic [5:0]        rec_idx_reg;
  logic              fetch_cnt_reg;
  logic [3:0]        byte_idx_reg;
  logic [3:0]        bit_idx_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic [4:0]        sel_reg;

  logic              trig_edge;
  logic [7:0]        hex_char [8];
  logic [7:0]        cur_byte;
  logic [2:0]        nib_sel;
  logic [3:0]        bit_next;
  logic              bit_next_val;

  assign trig_edge = trigger & ~trig_prev_reg;

  // ASCII form of each nibble of the record word; hex_char[7] is the MS nibble.
  // 0x37 + 0xA = 0x41 ('A').
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hex
      logic [3:0] nib;
      assign nib          = word_reg[4*gi +: 4];
      assign hex_char[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end
  endgenerate

  // Byte currently on the wire: 8 hex digits, then CR, then LF.
  always_comb begin
    cur_byte = 8'h0A;
    nib_sel  = 3'd7 - byte_idx_reg[2:0];
    if (byte_idx_reg < 4'd8) begin
      cur_byte = hex_char[nib_sel];
    end else if (byte_idx_reg == 4'd8) begin
      cur_byte = 8'h0D;
    end
  end

  // Bit slot index: 0 = start, 1..8 = data LSB first, 9 = stop.
  assign bit_next = bit_idx_reg + 4'd1;

  always_comb begin
    bit_next_val = 1'b1;
    if (bit_next <= 4'd8) begin
      bit_next_val = cur_byte[bit_idx_reg[2:0]];
    end
  end

  always_ff @(posedge clk) begin
    // The edge detector keeps sampling through reset. As a result, a trigger
    // level held high while rst is released is not taken as a new edge.
    trig_prev_reg <= trigger;

    if (rst) begin
      state_reg     <= IDLE;
      pc_snap_reg   <= '0;
      word_reg      <= '0;
      rec_idx_reg   <= '0;
      fetch_cnt_reg <= 1'b0;
      byte_idx_reg  <= '0;
      bit_idx_reg   <= '0;
      baud_cnt_reg  <= '0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      sel_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trig_edge) begin
            state_reg     <= FETCH;
            busy_reg      <= 1'b1;
            pc_snap_reg   <= dbg_pc;
            rec_idx_reg   <= '0;
            fetch_cnt_reg <= 1'b0;
            sel_reg       <= '0;
          end
        end

        FETCH: begin
          // Two cycles. The data is taken on the second cycle, so a register
          // file with one cycle of read latency works as well.
          fetch_cnt_reg <= 1'b1;
          if (fetch_cnt_reg) begin
            word_reg     <= (rec_idx_reg == 6'd0) ? pc_snap_reg : dbg_reg_data;
            state_reg    <= SEND;
            tx_reg       <= 1'b0;
            byte_idx_reg <= '0;
            bit_idx_reg  <= '0;
            baud_cnt_reg <= '0;
          end
        end

        SEND: begin
          if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == STOP_BIT) begin
              if (byte_idx_reg == LAST_BYTE) begin
                if (rec_idx_reg == LAST_REC) begin
                  state_reg <= DONE;
                end else begin
                  // The next record reads register rec_idx_reg (= next r - 1).
                  // It is presented from the first FETCH cycle.
                  rec_idx_reg   <= rec_idx_reg + 6'd1;
                  sel_reg       <= rec_idx_reg[4:0];
                  fetch_cnt_reg <= 1'b0;
                  state_reg     <= FETCH;
                end
              end else begin
                byte_idx_reg <= byte_idx_reg + 4'd1;
                bit_idx_reg  <= '0;
                tx_reg       <= 1'b0;
              end
            end else begin
              bit_idx_reg <= bit_next;
              tx_reg      <= bit_next_val;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dbg_reg_sel = sel_reg;
  assign tx          = tx_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_dbg_uart_dump.sv
// -----------------------------------------------------------------------------
// tb_dbg_uart_dump
//
// Exercises dbg_uart_dump with CLKS_PER_BIT=4. A register file model supports
// two read modes: combinational, or registered with one cycle of latency.
// The expected tx waveform and byte stream are built from the formatting
// rules using plain arithmetic. They are compared against the observed tx
// line, the decoded bytes, the busy length and dbg_reg_sel.
// -----------------------------------------------------------------------------
module tb_dbg_uart_dump;

  localparam int CPB      = 4;
  localparam int REC_CYC  = 2 + 100 * CPB;
  localparam int DUMP_CYC = 33 * REC_CYC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_reg_data;
  logic [4:0]  dbg_reg_sel;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  dbg_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .dbg_pc       (dbg_pc),
    .dbg_reg_data (dbg_reg_data),
    .dbg_reg_sel  (dbg_reg_sel),
    .tx           (tx),
    .busy         (busy)
  );

  // Register file model: combinational read, or one cycle of read latency.
  logic [31:0] regs [32];
  logic [31:0] rd_q;
  bit          reg_mode;

  always @(posedge clk) rd_q <= regs[dbg_reg_sel];
  assign dbg_reg_data = reg_mode ? rd_q : regs[dbg_reg_sel];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_bytes [$];
  logic       exp_wave  [$];
  logic       obs_wave  [$];
  logic [4:0] obs_sel   [$];
  logic [7:0] dec_bytes [$];

  // Expected stream: 33 records of "%08X\r\n".
  // Waveform: 2 idle-high fetch cycles per record, 10 framed bytes, then one DONE cycle.
  task automatic build_expected(input logic [31:0] pc);
    logic [31:0] w;
    logic [3:0]  nib;
    logic [7:0]  v;
    exp_bytes.delete();
    exp_wave.delete();
    for (int r = 0; r < 33; r++) begin
      w = (r == 0) ? pc : regs[r-1];
      for (int c = 0; c < 8; c++) begin
        nib = w[31 - 4*c -: 4];
        exp_bytes.push_back((nib < 10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10));
      end
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
    end
    for (int r = 0; r < 33; r++) begin
      exp_wave.push_back(1'b1);
      exp_wave.push_back(1'b1);
      for (int b = 0; b < 10; b++) begin
        v = exp_bytes[r*10 + b];
        repeat (CPB) exp_wave.push_back(1'b0);
        for (int k = 0; k < 8; k++) repeat (CPB) exp_wave.push_back(v[k]);
        repeat (CPB) exp_wave.push_back(1'b1);
      end
    end
    exp_wave.push_back(1'b1);
  endtask

  // Starts a dump and records tx/dbg_reg_sel for every busy cycle.
  // retrig: pulse trigger mid-dump, then hold it high across the end of the dump.
  // abort_at: if nonzero, assert rst on that busy cycle and check the reset outputs.
  task automatic run_dump(input logic [31:0] pc, input bit retrig, input int abort_at, input string tag);
    int n;
    int errs;
    int i;
    int sz;
    logic [7:0] b;
    dbg_pc = pc;
    build_expected(pc);
    obs_wave.delete();
    obs_sel.delete();
    dec_bytes.delete();
    @(negedge clk) trigger = 1'b0;
    @(negedge clk) trigger = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < DUMP_CYC + 50) begin
      @(negedge clk);
      if (!busy) break;
      obs_wave.push_back(tx);
      obs_sel.push_back(dbg_reg_sel);
      n++;
      if (n == 3) begin
        trigger = 1'b0;
        if (retrig) dbg_pc = $urandom;
      end
      if (retrig) begin
        if (n == 500) trigger = 1'b1;
        if (n == 520) trigger = 1'b0;
        if (n == DUMP_CYC - 5) trigger = 1'b1;
      end
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_tx"}, tx, 1'b1);
        check({tag, "_rst_busy"}, busy, 1'b0);
        check({tag, "_rst_sel"}, dbg_reg_sel, 5'd0);
        rst = 1'b0;
        $display("dump %s: reset applied at busy cycle %0d", tag, n);
        return;
      end
    end
    if (abort_at != 0) begin
      check({tag, "_abort_reached"}, n, abort_at);
      return;
    end
    check({tag, "_busy_len"}, n, DUMP_CYC);

    errs = 0;
    sz = obs_wave.size();
    for (int k = 0; k < exp_wave.size(); k++) begin
      if (k >= sz) errs++;
      else if (obs_wave[k] !== exp_wave[k]) errs++;
    end
    check({tag, "_tx_wave_errs"}, errs, 0);

    for (int r = 1; r < 33; r++) begin
      check({tag, "_sel_fetch"}, (r*REC_CYC + 1 < sz) ? 64'(obs_sel[r*REC_CYC]) : 64'hDEAD, r - 1);
    end

    // Decode the line by sampling each bit in the middle of its slot.
    i = 0;
    while (i < sz) begin
      if (obs_wave[i] == 1'b0 && i + 10*CPB <= sz) begin
        for (int k = 0; k < 8; k++) b[k] = obs_wave[i + (k+1)*CPB + CPB/2];
        dec_bytes.push_back(b);
        i += 9*CPB + CPB/2;
      end else begin
        i++;
      end
    end
    check({tag, "_byte_count"}, dec_bytes.size(), 330);
    errs = 0;
    for (int k = 0; k < 330; k++) begin
      if (k >= dec_bytes.size()) errs++;
      else if (dec_bytes[k] !== exp_bytes[k]) errs++;
    end
    check({tag, "_byte_errs"}, errs, 0);
    $display("dump %s: pc=%08h busy=%0d cycles bytes=%0d", tag, pc, n, dec_bytes.size());
  endtask

  string      ref_prefix;
  string      ref_rec6;
  logic [7:0] first_byte;
  int         busy_cnt;
  logic       exp_bit;

  initial begin
    rst      = 1'b1;
    trigger  = 1'b1;
    dbg_pc   = '0;
    reg_mode = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h11111111;
    regs[5] = 32'hDEADBEEF;

    // Reset with trigger held high
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sel", dbg_reg_sel, 5'd0);
    rst = 1'b0;
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("no_dump_after_rst", busy_cnt, 0);
    $display("reset: trigger held high through release, busy cycles=%0d", busy_cnt);
    trigger = 1'b0;

    // Full dump with the reference register file
    run_dump(32'h00000010, 1'b0, 0, "spec");
    ref_prefix = "00000010\r\n00000000\r\n11111111\r\n";
    for (int k = 0; k < 30; k++)
      check("spec_prefix", (k < dec_bytes.size()) ? 64'(dec_bytes[k]) : 64'hFFF, ref_prefix[k]);
    ref_rec6 = "DEADBEEF\r\n";
    for (int k = 0; k < 10; k++)
      check("spec_rec6", (60 + k < dec_bytes.size()) ? 64'(dec_bytes[60 + k]) : 64'hFFF, ref_rec6[k]);
    // First byte '0': start, bits 0,0,0,0,1,1,0,0, stop -- each CPB cycles from T+3
    first_byte = 8'h30;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k / CPB == 0) exp_bit = 1'b0;
      else if (k / CPB == 9) exp_bit = 1'b1;
      else exp_bit = first_byte[k/CPB - 1];
      check("spec_first_byte_bit", (2 + k < obs_wave.size()) ? 64'(obs_wave[2 + k]) : 64'hF, exp_bit);
    end

    // Registered read, retrigger during the dump, trigger held high at the end
    reg_mode = 1'b1;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    run_dump($urandom, 1'b1, 0, "retrig");
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("no_second_dump", busy_cnt, 0);
    $display("retrig: trigger held after dump, busy cycles=%0d", busy_cnt);
    trigger = 1'b0;

    // Fresh edge after busy falls starts a new dump
    reg_mode = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    run_dump($urandom, 1'b0, 0, "fresh");

    // Reset during record 10, byte 3, then a complete dump from record 0
    run_dump($urandom, 1'b0, 10*REC_CYC + 2 + 3*10*CPB + 5, "abort");
    reg_mode = 1'b1;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    run_dump($urandom, 1'b0, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
